dff_pipe: RTL and testbench

DFF_PIPE -- requirements
Module: dff_pipe

---
 rtl/dff_pkg.sv | 13 +
 rtl/dff_stage.sv | 39 +++
 rtl/dff_pipe.sv | 102 ++++++++++
 tb/tb_dff_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// dff_pkg: shared defaults and helpers for the dff_pipe elastic pipeline.
//   DFF_WIDTH_DEF / DFF_DEPTH_DEF : default data width and stage count
//   occ_width(depth)              : bits needed to hold an occupancy of 0..depth
package dff_pkg;

  localparam int unsigned DFF_WIDTH_DEF = 8;
  localparam int unsigned DFF_DEPTH_DEF = 4;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// dff_stage: one pipeline slot, a valid bit plus a data register.
//   clk, rst  : clock, asynchronous active-high reset (valid=0, data=RESET_VAL)
//   i_load    : write i_data into the slot and mark it valid
//   i_clr     : mark the slot empty (ignored when i_load is high); data is kept
//   i_data    : incoming word
//   o_valid   : slot holds a word
//   o_data    : stored word (holds its value unless loaded)
module dff_stage #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= RESET_VAL;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: elastic valid/ready pipeline of DEPTH register stages.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous clear of every stage valid bit (data untouched)
//   in_valid   : upstream word present        in_ready : block accepts in_data
//   in_data    : upstream word
//   out_valid  : last stage holds a word      out_ready: downstream accepts it
//   out_data   : last stage data register
//   occupancy  : number of words held (0..DEPTH)
// Stage 0 takes the input; stage DEPTH-1 drives the outputs straight from
// flops. The only combinational path is out_ready -> advance chain -> in_ready
// (plus rst/flush forcing in_ready low).
module dff_pipe
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH     = DFF_WIDTH_DEF,
  parameter int unsigned      DEPTH     = DFF_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int unsigned      OW      = occ_width(DEPTH);
  localparam logic [OW-1:0]    OCC_ONE = OW'(1);

  logic             w_vld  [DEPTH];
  logic [WIDTH-1:0] w_dat  [DEPTH];
  logic             w_adv  [DEPTH];
  logic             w_load [DEPTH];
  logic             w_clr  [DEPTH];
  logic [WIDTH-1:0] w_din  [DEPTH];
  logic             w_in_hs;
  logic             w_out_hs;
  logic [OW-1:0]    r_occ;

  // The recursive "next stage empty or advancing" rule is flattened: stage i
  // advances when it is valid and either out_ready is high or some stage
  // downstream of it is empty. Walking from the output back keeps this a
  // single combinational pass with no self-dependent vector.
  always_comb begin : adv_chain
    logic w_path;
    w_path = out_ready;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_adv[DEPTH-1-k] = w_vld[DEPTH-1-k] && w_path;
      w_path           = w_path || !w_vld[DEPTH-1-k];
    end
  end

  assign in_ready  = !rst && !flush && (!w_vld[0] || w_adv[0]);
  assign w_in_hs   = in_valid && in_ready;
  assign out_valid = w_vld[DEPTH-1];
  assign out_data  = w_dat[DEPTH-1];
  assign w_out_hs  = out_valid && out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_din[g]  = in_data;
      assign w_load[g] = w_in_hs;
    end else begin : g_body
      // Flush must leave data registers untouched, so inter-stage loads are gated.
      assign w_din[g]  = w_dat[g-1];
      assign w_load[g] = w_adv[g-1] && !flush;
    end
    assign w_clr[g] = flush || w_adv[g];

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[g]),
      .i_clr   (w_clr[g]),
      .i_data  (w_din[g]),
      .o_valid (w_vld[g]),
      .o_data  (w_dat[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (w_in_hs && !w_out_hs) begin
      r_occ <= r_occ + OCC_ONE;
    end else if (!w_in_hs && w_out_hs) begin
      r_occ <= r_occ - OCC_ONE;
    end
  end

  assign occupancy = r_occ;

endmodule

// File: tb/tb_dff_pipe.sv
module tb_dff_pipe;

  localparam int MD = 4;

  logic       clk;
  logic       rst;
  logic       flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] occupancy;

  logic       flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [7:0] in_data1, out_data1;
  logic [0:0] occupancy1;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .occupancy(occupancy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: words in flight with their slot positions (0..MD-1).
  logic [7:0] mq[$];
  int         mp[$];
  logic [7:0] m_last;
  logic [7:0] got[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    mp.delete();
    m_last = 8'hA5;
  endtask

  // One clock cycle on the DEPTH=4 instance: drive, compare against the
  // model, advance the model, then move to just after the next rising edge.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy,
                       input logic fl, output logic acc);
    int   np[$];
    int   lim;
    int   p;
    logic ov_e, ohs, ir_e;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    ov_e = (mq.size() > 0) && (mp[0] == MD - 1);
    ohs  = ov_e && ordy;
    lim  = MD;
    for (int k = 0; k < mq.size(); k++) begin
      if (k == 0 && ohs) continue;
      p = mp[k] + 1;
      if (p > lim - 1) p = lim - 1;
      np.push_back(p);
      lim = p;
    end
    ir_e = !fl && (lim > 0);
    chk("in_ready",  int'(in_ready),  int'(ir_e));
    chk("out_valid", int'(out_valid), int'(ov_e));
    chk("out_data",  int'(out_data),  int'(m_last));
    chk("occupancy", int'(occupancy), mq.size());
    if (out_valid && ordy) got.push_back(out_data);
    acc = iv && ir_e;
    if (fl) begin
      mq.delete();
      mp.delete();
    end else begin
      if (ohs) void'(mq.pop_front());
      mp = np;
      if (acc) begin
        mq.push_back(d);
        mp.push_back(0);
      end
      if (mq.size() > 0 && mp[0] == MD - 1) m_last = mq[0];
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_occ;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic       acc;
    logic [7:0] w;
    int         first_acc, first_ov;

    tbl[0] = '{1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h10, 1'b1};
    tbl[2] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h10, 1'b1};
    tbl[3] = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
    tbl[4] = '{1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1};
    tbl[5] = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 8'h12, 1'b1};
    tbl[6] = '{1'b1, 8'h13, 1'b1, 1'b1, 1'b1, 8'h12, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h13, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h13, 1'b0};

    rst = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data), 8'hA5);
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_in_ready",  int'(in_ready), 0);
    chk("rst_d1_out_data", int'(out_data1), 0);
    chk("rst_d1_in_ready", int'(in_ready1), 0);
    rst = 1'b0;
    model_reset();

    // DEPTH=1 register slice, alternating out_ready
    for (int i = 0; i < 9; i++) begin
      in_valid1  = tbl[i].iv;
      in_data1   = tbl[i].d;
      out_ready1 = tbl[i].ordy;
      #1;
      chk($sformatf("d1_in_ready[%0d]", i),  int'(in_ready1),  int'(tbl[i].e_ir));
      chk($sformatf("d1_out_valid[%0d]", i), int'(out_valid1), int'(tbl[i].e_ov));
      chk($sformatf("d1_out_data[%0d]", i),  int'(out_data1),  int'(tbl[i].e_od));
      chk($sformatf("d1_occupancy[%0d]", i), int'(occupancy1), int'(tbl[i].e_occ));
      @(posedge clk);
      #1;
    end
    in_valid1 = 1'b0;

    // Streaming 0x01..0x10 with out_ready held high
    got.delete();
    first_acc = -1;
    first_ov  = -1;
    for (int c = 0; c < 24; c++) begin
      if (out_valid && first_ov < 0) first_ov = c;
      if (c >= 4 && c <= 16) chk("stream_occupancy", int'(occupancy), 4);
      if (c >= 4 && c <= 19) chk("stream_no_bubble", int'(out_valid), 1);
      cycle(c < 16, 8'(c + 1), 1'b1, 1'b0, acc);
      if (acc && first_acc < 0) first_acc = c;
    end
    chk("stream_latency", first_ov - first_acc, 4);
    chk("stream_count", got.size(), 16);
    for (int i = 0; i < got.size(); i++) chk("stream_order", int'(got[i]), i + 1);

    // Stall until full, then full-pipe throughput, then drain
    got.delete();
    w = 8'h20;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b1, w, 1'b0, 1'b0, acc);
      if (acc) w++;
    end
    chk("stall_occupancy", int'(occupancy), 4);
    chk("stall_in_ready",  int'(in_ready), 0);
    chk("stall_out_data",  int'(out_data), 8'h20);
    for (int c = 0; c < 5; c++) begin
      chk("full_occupancy", int'(occupancy), 4);
      cycle(1'b1, w, 1'b1, 1'b0, acc);
      chk("full_accept", int'(acc), 1);
      if (acc) w++;
    end
    for (int c = 0; c < 8; c++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("stall_count", got.size(), 9);
    for (int i = 0; i < got.size(); i++) chk("stall_order", int'(got[i]), 8'h20 + i);

    // Flush with three words in flight and a word offered
    got.delete();
    for (int c = 0; c < 3; c++) cycle(1'b1, 8'(8'h40 + c), 1'b0, 1'b0, acc);
    chk("flush_pre_occupancy", int'(occupancy), 3);
    cycle(1'b1, 8'h4F, 1'b0, 1'b1, acc);
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_occupancy", int'(occupancy), 0);
    for (int c = 0; c < 6; c++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("flush_nothing_out", got.size(), 0);

    // Asynchronous reset between edges on a full pipe
    for (int c = 0; c < 4; c++) cycle(1'b1, 8'(8'h60 + c), 1'b0, 1'b0, acc);
    chk("arst_pre_occupancy", int'(occupancy), 4);
    rst = 1'b1;
    #2;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_data",  int'(out_data), 8'hA5);
    chk("arst_occupancy", int'(occupancy), 0);
    chk("arst_in_ready",  int'(in_ready), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
    cycle(1'b1, 8'h77, 1'b1, 1'b0, acc);
    chk("arst_first_accept", int'(acc), 1);
    for (int c = 0; c < 6; c++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("arst_count", got.size(), 1);
    if (got.size() > 0) chk("arst_word", int'(got[0]), 8'h77);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 3, acc);
    end
    for (int c = 0; c < 8; c++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("random_drained", int'(occupancy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
